// File: rtl/id_ctrl_pipe.sv
// ID-stage control for the 5-stage MIPS pipeline: decode, branch/jump resolve, RAW hazards, ID/EX and EX/MEM write shadow, MUL busy counter.
// Optional macro FORWARD_EN enables operand forwarding and reduces stalls to load-use and branch-compare cases.
module id_ctrl_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RF_AW   = 5,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              flush_if,
    output logic              jump,
    output logic [1:0]        mux_pc,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              ex_valid,
    output logic [3:0]        ex_aluc,
    output logic              ex_mux_alua,
    output logic [1:0]        ex_mux_alub,
    output logic [1:0]        ex_mux_wdata,
    output logic [RF_AW-1:0]  ex_waddr,
    output logic              ex_write,
    output logic              ex_dm_w,
    output logic              mdu_busy
);
    localparam int unsigned CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_MUL = 6'b011100;

    localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR = 6'b001000, F_MUL = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110, F_NOR = 6'b100111, F_SLT = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    typedef struct packed {
        logic             valid;
        logic [3:0]       aluc;
        logic             mux_alua;
        logic [1:0]       mux_alub;
        logic [1:0]       mux_wdata;
        logic [RF_AW-1:0] waddr;
        logic             write;
        logic             dm_w;
        logic             is_lw;
    } ctrl_t;

    logic [5:0]       op, func;
    logic [RF_AW-1:0] rs_a, rt_a, rd_a, dest;
    ctrl_t            dec, ex_q;
    logic             wr, uses_rs, uses_rt, is_jmp, is_jr, is_beq, is_bne, is_mul;
    logic             mem_valid, mem_write, mem_is_lw;
    logic [RF_AW-1:0] mem_waddr;
    logic [CNT_W-1:0] mdu_cnt;
    logic             ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, hazard, take, load;
    logic             unused_shamt;

    assign op           = instr[31:26];
    assign func         = instr[5:0];
    assign rs_a         = RF_AW'(instr[25:21]);
    assign rt_a         = RF_AW'(instr[20:16]);
    assign rd_a         = RF_AW'(instr[15:11]);
    assign unused_shamt = ^instr[10:6];

    // Instruction decode into the ID/EX control payload
    always_comb begin
        dec     = '0;
        dest    = rt_a;
        wr      = 1'b0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_jmp  = 1'b0;
        is_jr   = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_mul  = 1'b0;
        case (op)
            OP_R: begin
                dest         = rd_a;
                wr           = 1'b1;
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
                dec.mux_alub = 2'b10;
                case (func)
                    F_ADD:  dec.aluc = 4'b0010;
                    F_ADDU: dec.aluc = 4'b0000;
                    F_SUB:  dec.aluc = 4'b0011;
                    F_SUBU: dec.aluc = 4'b0001;
                    F_AND:  dec.aluc = 4'b0100;
                    F_OR:   dec.aluc = 4'b0101;
                    F_XOR:  dec.aluc = 4'b0110;
                    F_NOR:  dec.aluc = 4'b0111;
                    F_SLT:  dec.aluc = 4'b1011;
                    F_SLTU: dec.aluc = 4'b1010;
                    F_SLLV: dec.aluc = 4'b1110;
                    F_SRLV: dec.aluc = 4'b1101;
                    F_SRAV: dec.aluc = 4'b1100;
                    F_SLL: begin
                        dec.aluc     = 4'b1110;
                        dec.mux_alua = 1'b1;
                        uses_rs      = 1'b0;
                    end
                    F_SRL: begin
                        dec.aluc     = 4'b1101;
                        dec.mux_alua = 1'b1;
                        uses_rs      = 1'b0;
                    end
                    F_SRA: begin
                        dec.aluc     = 4'b1100;
                        dec.mux_alua = 1'b1;
                        uses_rs      = 1'b0;
                    end
                    F_JR: begin
                        wr           = 1'b0;
                        uses_rt      = 1'b0;
                        is_jr        = 1'b1;
                        dec.mux_alub = 2'b00;
                    end
                    default: begin
                        wr           = 1'b0;
                        uses_rs      = 1'b0;
                        uses_rt      = 1'b0;
                        dec.mux_alub = 2'b00;
                    end
                endcase
            end
            OP_ADDI:  begin wr = 1'b1; uses_rs = 1'b1; dec.aluc = 4'b0010; end
            OP_ADDIU: begin wr = 1'b1; uses_rs = 1'b1; dec.aluc = 4'b0000; end
            OP_SLTI:  begin wr = 1'b1; uses_rs = 1'b1; dec.aluc = 4'b1011; end
            OP_SLTIU: begin wr = 1'b1; uses_rs = 1'b1; dec.aluc = 4'b1010; end
            OP_ANDI:  begin wr = 1'b1; uses_rs = 1'b1; dec.aluc = 4'b0100; dec.mux_alub = 2'b01; end
            OP_ORI:   begin wr = 1'b1; uses_rs = 1'b1; dec.aluc = 4'b0101; dec.mux_alub = 2'b01; end
            OP_XORI:  begin wr = 1'b1; uses_rs = 1'b1; dec.aluc = 4'b0110; dec.mux_alub = 2'b01; end
            OP_LUI:   begin wr = 1'b1; dec.aluc = 4'b1000; dec.mux_alub = 2'b01; end
            OP_LW: begin
                wr            = 1'b1;
                uses_rs       = 1'b1;
                dec.aluc      = 4'b0010;
                dec.mux_wdata = 2'b01;
                dec.is_lw     = 1'b1;
            end
            OP_SW: begin
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                dec.aluc = 4'b0010;
                dec.dm_w = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
                is_beq       = (op == OP_BEQ);
                is_bne       = (op == OP_BNE);
                dec.aluc     = 4'b0011;
                dec.mux_alub = 2'b10;
            end
            OP_J: is_jmp = 1'b1;
            OP_JAL: begin
                is_jmp        = 1'b1;
                wr            = 1'b1;
                dest          = RF_AW'(5'd31);
                dec.mux_wdata = 2'b10;
            end
            OP_MUL: begin
                if (func == F_MUL) begin
                    is_mul        = 1'b1;
                    wr            = 1'b1;
                    uses_rs       = 1'b1;
                    uses_rt       = 1'b1;
                    dest          = rd_a;
                    dec.mux_alub  = 2'b10;
                    dec.mux_wdata = 2'b11;
                end
            end
            default: ;
        endcase
        dec.valid = 1'b1;
        dec.write = wr & (dest != '0);
        dec.waddr = dec.write ? dest : '0;
    end

    assign ex_hit_rs  = id_valid & uses_rs & ex_q.valid & ex_q.write & (ex_q.waddr != '0) & (ex_q.waddr == rs_a);
    assign ex_hit_rt  = id_valid & uses_rt & ex_q.valid & ex_q.write & (ex_q.waddr != '0) & (ex_q.waddr == rt_a);
    assign mem_hit_rs = id_valid & uses_rs & mem_valid & mem_write & (mem_waddr != '0) & (mem_waddr == rs_a);
    assign mem_hit_rt = id_valid & uses_rt & mem_valid & mem_write & (mem_waddr != '0) & (mem_waddr == rt_a);

`ifdef FORWARD_EN
    // Forwarding covers ALU results; only loads and ID-stage compares still need a bubble
    assign fwd_a_sel = ex_hit_rs ? 2'b01 : (mem_hit_rs ? 2'b10 : 2'b00);
    assign fwd_b_sel = ex_hit_rt ? 2'b01 : (mem_hit_rt ? 2'b10 : 2'b00);
    assign hazard    = (ex_q.is_lw & (ex_hit_rs | ex_hit_rt))
                     | ((is_beq | is_bne | is_jr)
                        & (ex_hit_rs | ex_hit_rt | (mem_is_lw & (mem_hit_rs | mem_hit_rt))));
`else
    logic unused_lw;
    assign unused_lw = ex_q.is_lw ^ mem_is_lw;
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    assign hazard    = ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt;
`endif

    // Redirect resolution; MUL freeze outranks hazard stall which outranks redirect
    assign mdu_busy = (mdu_cnt != '0);
    assign stall    = hazard & ~mdu_busy;
    assign take     = is_jmp | is_jr | (is_beq & (rs_data == rt_data)) | (is_bne & (rs_data != rt_data));
    assign jump     = take & id_valid & ~stall & ~mdu_busy;
    assign flush_if = jump;
    assign mux_pc   = !jump ? 2'b10 : (is_jmp ? 2'b00 : (is_jr ? 2'b01 : 2'b11));
    assign load     = id_valid & ~hazard;

    // ID/EX register, EX/MEM write shadow and MUL occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_waddr <= '0;
            mem_is_lw <= 1'b0;
            mdu_cnt   <= '0;
        end else if (mdu_busy) begin
            mdu_cnt <= mdu_cnt - CNT_W'(1);
        end else begin
            mem_valid <= ex_q.valid;
            mem_write <= ex_q.write;
            mem_waddr <= ex_q.waddr;
            mem_is_lw <= ex_q.is_lw;
            ex_q      <= load ? dec : '0;
            mdu_cnt   <= (load & is_mul) ? CNT_W'(MDU_LAT - 1) : '0;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_aluc      = ex_q.aluc;
    assign ex_mux_alua  = ex_q.mux_alua;
    assign ex_mux_alub  = ex_q.mux_alub;
    assign ex_mux_wdata = ex_q.mux_wdata;
    assign ex_waddr     = ex_q.waddr;
    assign ex_write     = ex_q.write;
    assign ex_dm_w      = ex_q.dm_w;
endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Scoreboard bench for id_ctrl_pipe: expected ID/EX payloads queued at issue, compared one edge later.
module tb_id_ctrl_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        id_valid = 1'b0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        stall, flush_if, jump, ex_valid, ex_mux_alua, ex_write, ex_dm_w, mdu_busy;
    logic [1:0]  mux_pc, fwd_a_sel, fwd_b_sel, ex_mux_alub, ex_mux_wdata;
    logic [3:0]  ex_aluc;
    logic [4:0]  ex_waddr;

    typedef struct packed {
        logic       valid;
        logic [3:0] aluc;
        logic       alua;
        logic [1:0] alub;
        logic [1:0] wdata;
        logic [4:0] waddr;
        logic       write;
        logic       dm_w;
    } ex_t;

    ex_t sb[$];
    ex_t exp_e, obs_e, mul_e;
    int  n_vec = 0;
    int  n_err = 0;

    id_ctrl_pipe #(.DATA_W(32), .RF_AW(5), .MDU_LAT(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid),
        .rs_data(rs_data), .rt_data(rt_data),
        .stall(stall), .flush_if(flush_if), .jump(jump), .mux_pc(mux_pc),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_valid(ex_valid), .ex_aluc(ex_aluc), .ex_mux_alua(ex_mux_alua),
        .ex_mux_alub(ex_mux_alub), .ex_mux_wdata(ex_mux_wdata), .ex_waddr(ex_waddr),
        .ex_write(ex_write), .ex_dm_w(ex_dm_w), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    function automatic ex_t mk(logic v, logic [3:0] a, logic sa, logic [1:0] b, logic [1:0] w,
                               logic [4:0] d, logic we, logic dw);
        return {v, a, sa, b, w, d, we, dw};
    endfunction

    function automatic ex_t sample_ex();
        return {ex_valid, ex_aluc, ex_mux_alua, ex_mux_alub, ex_mux_wdata, ex_waddr, ex_write, ex_dm_w};
    endfunction

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mul_i(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return {6'b011100, rs, rt, rd, 5'd0, 6'b000010};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        instr    = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        n_vec++; if (sample_ex() !== '0) begin n_err++; $display("FAIL reset_ex got=%h exp=0", sample_ex()); end
        n_vec++; if ({stall, jump, flush_if, mdu_busy} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got=%b exp=0000", {stall, jump, flush_if, mdu_busy}); end
        n_vec++; if ({mux_pc, fwd_a_sel, fwd_b_sel} !== 6'b100000) begin
            n_err++; $display("FAIL reset_sel got=%b exp=100000", {mux_pc, fwd_a_sel, fwd_b_sel}); end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        int n_bub;
        logic [1:0] exp_fwd;
`ifdef FORWARD_EN
        n_bub = 1; exp_fwd = 2'b10;
`else
        n_bub = 2; exp_fwd = 2'b00;
`endif
        idle(3);
        instr = itype(6'b100011, 5'd2, 5'd1, 16'h0000); id_valid = 1'b1; #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lw_stall got=%b exp=0", stall); end
        sb.push_back(mk(1, 4'b0010, 0, 2'b00, 2'b01, 5'd1, 1, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL lw_ex got=%h exp=%h", obs_e, exp_e); end
        instr = rtype(5'd1, 5'd4, 5'd3, 5'd0, 6'b100000); #1;
        for (int i = 0; i < n_bub; i++) begin
            n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall%0d got=%b exp=1", i, stall); end
            sb.push_back('0);
            tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
            n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL lu_bubble%0d got=%h exp=%h", i, obs_e, exp_e); end
        end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_release got=%b exp=0", stall); end
        n_vec++; if (fwd_a_sel !== exp_fwd) begin n_err++; $display("FAIL lu_fwd_a got=%b exp=%b", fwd_a_sel, exp_fwd); end
        sb.push_back(mk(1, 4'b0010, 0, 2'b10, 2'b00, 5'd3, 1, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL lu_add got=%h exp=%h", obs_e, exp_e); end
    endtask

    task automatic test_branch();
        logic [31:0] br_i[5];
        logic [31:0] rs_v[5];
        logic [2:0]  exp_r[5];
        ex_t         exp_x[5];
        br_i[0] = itype(6'b000100, 5'd1, 5'd2, 16'h4); rs_v[0] = 32'h5;         exp_r[0] = 3'b111;
        br_i[1] = itype(6'b000101, 5'd1, 5'd2, 16'h4); rs_v[1] = 32'h5;         exp_r[1] = 3'b010;
        br_i[2] = itype(6'b000100, 5'd1, 5'd2, 16'h4); rs_v[2] = 32'h8000_0005; exp_r[2] = 3'b010;
        br_i[3] = itype(6'b000101, 5'd1, 5'd2, 16'h4); rs_v[3] = 32'h8000_0005; exp_r[3] = 3'b111;
        br_i[4] = rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'b001000); rs_v[4] = 32'h5;    exp_r[4] = 3'b101;
        for (int i = 0; i < 4; i++) exp_x[i] = mk(1, 4'b0011, 0, 2'b10, 2'b00, 5'd0, 0, 0);
        exp_x[4] = mk(1, 4'b0000, 0, 2'b00, 2'b00, 5'd0, 0, 0);
        idle(3);
        rt_data = 32'h5;
        for (int i = 0; i < 5; i++) begin
            instr = br_i[i]; rs_data = rs_v[i]; id_valid = 1'b1; #1;
            n_vec++; if ({jump, mux_pc} !== exp_r[i]) begin
                n_err++; $display("FAIL br%0d_redirect got=%b exp=%b", i, {jump, mux_pc}, exp_r[i]); end
            n_vec++; if (flush_if !== exp_r[i][2]) begin
                n_err++; $display("FAIL br%0d_flush got=%b exp=%b", i, flush_if, exp_r[i][2]); end
            sb.push_back(exp_x[i]);
            tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
            n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL br%0d_ex got=%h exp=%h", i, obs_e, exp_e); end
        end
    endtask

    task automatic test_mul();
        idle(3);
        mul_e = mk(1, 4'b0000, 0, 2'b10, 2'b11, 5'd5, 1, 0);
        instr = mul_i(5'd6, 5'd7, 5'd5); id_valid = 1'b1; #1;
        n_vec++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL mul_prebusy got=%b exp=0", mdu_busy); end
        sb.push_back(mul_e);
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL mul_ex got=%h exp=%h", obs_e, exp_e); end
        instr = {6'b000010, 26'h10}; #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if ({mdu_busy, jump, stall} !== 3'b100) begin
                n_err++; $display("FAIL mul_busy%0d got=%b exp=100", i, {mdu_busy, jump, stall}); end
            obs_e = sample_ex();
            n_vec++; if (obs_e !== mul_e) begin n_err++; $display("FAIL mul_hold%0d got=%h exp=%h", i, obs_e, mul_e); end
            tick();
        end
        n_vec++; if ({mdu_busy, jump, mux_pc} !== 4'b0100) begin
            n_err++; $display("FAIL mul_done got=%b exp=0100", {mdu_busy, jump, mux_pc}); end
        sb.push_back(mk(1, 4'b0000, 0, 2'b00, 2'b00, 5'd0, 0, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL mul_next got=%h exp=%h", obs_e, exp_e); end
    endtask

    task automatic test_reset_mid_mul();
        idle(3);
        instr = mul_i(5'd6, 5'd7, 5'd5); id_valid = 1'b1;
        tick();
        id_valid = 1'b0; instr = '0;
        tick();
        n_vec++; if (mdu_busy !== 1'b1) begin n_err++; $display("FAIL rmul_busy got=%b exp=1", mdu_busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({mdu_busy, ex_valid, ex_write} !== 3'b000) begin
            n_err++; $display("FAIL rmul_async got=%b exp=000", {mdu_busy, ex_valid, ex_write}); end
        #1 rst = 1'b0;
        tick();
        n_vec++; if ({mdu_busy, ex_valid} !== 2'b00) begin
            n_err++; $display("FAIL rmul_after got=%b exp=00", {mdu_busy, ex_valid}); end
    endtask

    task automatic test_zero_dest_jal();
        idle(3);
        instr = itype(6'b001000, 5'd1, 5'd0, 16'd7); id_valid = 1'b1; #1;
        sb.push_back(mk(1, 4'b0010, 0, 2'b00, 2'b00, 5'd0, 0, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL addi0_ex got=%h exp=%h", obs_e, exp_e); end
        instr = rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'b100000); #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_stall got=%b exp=0", stall); end
        sb.push_back(mk(1, 4'b0010, 0, 2'b10, 2'b00, 5'd3, 1, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL r0_ex got=%h exp=%h", obs_e, exp_e); end
        instr = {6'b000011, 26'h40}; #1;
        n_vec++; if ({jump, flush_if, mux_pc} !== 4'b1100) begin
            n_err++; $display("FAIL jal_redirect got=%b exp=1100", {jump, flush_if, mux_pc}); end
        sb.push_back(mk(1, 4'b0000, 0, 2'b00, 2'b10, 5'd31, 1, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL jal_ex got=%h exp=%h", obs_e, exp_e); end
    endtask

    task automatic test_raw_alu();
        int n_bub;
        logic [1:0] exp_fwd;
`ifdef FORWARD_EN
        n_bub = 0; exp_fwd = 2'b01;
`else
        n_bub = 2; exp_fwd = 2'b00;
`endif
        idle(3);
        instr = rtype(5'd2, 5'd3, 5'd1, 5'd0, 6'b100000); id_valid = 1'b1; #1;
        sb.push_back(mk(1, 4'b0010, 0, 2'b10, 2'b00, 5'd1, 1, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL raw_add got=%h exp=%h", obs_e, exp_e); end
        instr = rtype(5'd1, 5'd3, 5'd2, 5'd0, 6'b100010); #1;
        n_vec++; if ({fwd_a_sel, fwd_b_sel} !== {exp_fwd, 2'b00}) begin
            n_err++; $display("FAIL raw_fwd got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, {exp_fwd, 2'b00}); end
        for (int i = 0; i < n_bub; i++) begin
            n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_stall%0d got=%b exp=1", i, stall); end
            sb.push_back('0);
            tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
            n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL raw_bubble%0d got=%h exp=%h", i, obs_e, exp_e); end
        end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL raw_release got=%b exp=0", stall); end
        sb.push_back(mk(1, 4'b0011, 0, 2'b10, 2'b00, 5'd2, 1, 0));
        tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
        n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL raw_sub got=%h exp=%h", obs_e, exp_e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq_i[7];
        logic        seq_v[7];
        ex_t         seq_x[7];
        seq_i[0] = itype(6'b001101, 5'd0, 5'd4, 16'h00ff);     seq_v[0] = 1;
        seq_x[0] = mk(1, 4'b0101, 0, 2'b01, 2'b00, 5'd4, 1, 0);
        seq_i[1] = rtype(5'd0, 5'd6, 5'd5, 5'd3, 6'b000000);   seq_v[1] = 1;
        seq_x[1] = mk(1, 4'b1110, 1, 2'b10, 2'b00, 5'd5, 1, 0);
        seq_i[2] = itype(6'b101011, 5'd8, 5'd7, 16'h0004);     seq_v[2] = 1;
        seq_x[2] = mk(1, 4'b0010, 0, 2'b00, 2'b00, 5'd0, 0, 1);
        seq_i[3] = {6'b111111, 5'd1, 5'd2, 16'h1234};          seq_v[3] = 1;
        seq_x[3] = mk(1, 4'b0000, 0, 2'b00, 2'b00, 5'd0, 0, 0);
        seq_i[4] = itype(6'b001101, 5'd0, 5'd4, 16'h00ff);     seq_v[4] = 0;
        seq_x[4] = '0;
        seq_i[5] = itype(6'b001011, 5'd4, 5'd9, 16'h0001);     seq_v[5] = 1;
        seq_x[5] = mk(1, 4'b1010, 0, 2'b00, 2'b00, 5'd9, 1, 0);
        seq_i[6] = itype(6'b001111, 5'd0, 5'd10, 16'h1234);    seq_v[6] = 1;
        seq_x[6] = mk(1, 4'b1000, 0, 2'b01, 2'b00, 5'd10, 1, 0);
        idle(3);
        for (int i = 0; i < 7; i++) begin
            instr = seq_i[i]; id_valid = seq_v[i]; #1;
            n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b%0d_stall got=%b exp=0", i, stall); end
            sb.push_back(seq_x[i]);
            tick(); exp_e = sb.pop_front(); obs_e = sample_ex();
            n_vec++; if (obs_e !== exp_e) begin n_err++; $display("FAIL b2b%0d_ex got=%h exp=%h", i, obs_e, exp_e); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_reset_mid_mul();
        test_zero_dest_jal();
        test_raw_alu();
        test_back_to_back();
        idle(2);
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
